// File: rtl/load_store_unit_if.sv
// Core <-> load/store unit request/response channel.
//   master : core side, drives the request, receives the completion.
//   slave  : load_store_unit side.
// Request : req_valid/req_ready handshake, req_store (1=store), req_funct3
//           (RISC-V size/sign code), req_addr (byte address), req_wdata
//           (right-aligned store data).
// Response: resp_valid one-cycle pulse, resp_rdata (extended load data),
//           resp_fault.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine in front of a
// 64-bit-wide data memory with combinational read and edge-committed write.
//   clk, rst      : clock; asynchronous active-low reset
//   bus (slave)   : request/response channel (load_store_unit_if)
//   address       : dword index into memory, driven in RD/WR only
//   WriteData     : full dword written while MemWrite=1
//   MemRead       : read enable (RD state)
//   MemWrite      : write enable (WR state)
//   ReadData      : combinational memory read data
// Sub-dword stores are read-modify-write (RD then WR).
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned h/w/d accesses
// fault; otherwise the low address bits are truncated to natural alignment.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  load_store_unit_if.slave bus,
  output logic [63:0] address,
  output logic [63:0] WriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [63:0] ReadData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef struct packed {
    logic        store;
    logic        fault;
    logic [2:0]  funct3;
    logic [63:0] addr;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q;
  // Holds store data at accept, then the merged dword (sub-dword store) or
  // the extended result (load) once RD completes.
  logic [63:0] data_q;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_MISALIGN = 1'b1;
`else
  localparam logic TRAP_MISALIGN = 1'b0;
`endif

  // ---------------- accept-time decode ----------------
  logic        misal, oor, illegal, fault_dec, accept;
  logic [63:0] addr_eff;

  always_comb begin
    misal    = 1'b0;
    addr_eff = bus.req_addr;
    // funct3[1:0] encodes size for both signed and unsigned loads
    case (bus.req_funct3[1:0])
      2'b01: begin misal = bus.req_addr[0];     addr_eff[0]   = 1'b0;  end
      2'b10: begin misal = |bus.req_addr[1:0];  addr_eff[1:0] = 2'b00; end
      2'b11: begin misal = |bus.req_addr[2:0];  addr_eff[2:0] = 3'b000; end
      default: ;
    endcase
  end

  assign oor       = {3'b000, bus.req_addr[63:3]} >= 64'(MEM_WORDS);
  assign illegal   = (bus.req_funct3 == 3'b111) || (bus.req_store && bus.req_funct3[2]);
  // With trapping enabled a misaligned access faults before touching
  // memory, so registering the truncated address is harmless either way.
  assign fault_dec = illegal || oor || (TRAP_MISALIGN && misal);
  assign accept    = (state_q == IDLE) && bus.req_valid;

  // ---------------- lane extract / merge ----------------
  logic [5:0]  sh;
  logic [63:0] lane, ext, mask, merged;

  assign sh   = {req_q.addr[2:0], 3'b000};
  assign lane = ReadData >> sh;

  always_comb begin
    case (req_q.funct3)
      3'b000:  ext = {{56{lane[7]}},  lane[7:0]};
      3'b001:  ext = {{48{lane[15]}}, lane[15:0]};
      3'b010:  ext = {{32{lane[31]}}, lane[31:0]};
      3'b100:  ext = {56'd0, lane[7:0]};
      3'b101:  ext = {48'd0, lane[15:0]};
      3'b110:  ext = {32'd0, lane[31:0]};
      default: ext = ReadData;
    endcase
    case (req_q.funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_FFFF_FFFF;
    endcase
    merged = (ReadData & ~(mask << sh)) | ((data_q & mask) << sh);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.store  <= bus.req_store;
        req_q.fault  <= fault_dec;
        req_q.funct3 <= bus.req_funct3;
        req_q.addr   <= addr_eff;
        data_q       <= bus.req_wdata;
      end else if (state_q == RD) begin
        data_q <= req_q.store ? merged : ext;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_fault = 1'b0;
    bus.resp_rdata = '0;
    address        = '0;
    WriteData      = '0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (fault_dec)                                    state_d = RESP;
          else if (bus.req_store && bus.req_funct3 == 3'b011) state_d = WR;
          else                                              state_d = RD;
        end
      end
      RD: begin
        MemRead = 1'b1;
        address = {3'b000, req_q.addr[63:3]};
        state_d = req_q.store ? WR : RESP;
      end
      WR: begin
        MemWrite  = 1'b1;
        address   = {3'b000, req_q.addr[63:3]};
        WriteData = data_q;
        state_d   = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_fault = req_q.fault;
        bus.resp_rdata = (req_q.store || req_q.fault) ? 64'd0 : data_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] address, WriteData, ReadData;
  logic        MemRead, MemWrite;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .address(address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  // data memory model
  logic [63:0] mem [0:1023];
  assign ReadData = (MemRead && address < 64'd1024) ? mem[address[9:0]] : 64'd0;
  always @(posedge clk) if (MemWrite && address < 64'd1024) mem[address[9:0]] <= WriteData;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait (bounded) for the completion, compare against
  // the scoreboard entry and the memory-enable activity seen meanwhile.
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] erd, input logic ef, input int elat,
                         input logic exp_mr, input logic exp_mw);
    exp_t e;
    int   cyc;
    logic seen_rd, seen_wr, both;
    e.rdata = erd; e.fault = ef; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1; seen_rd = 1'b0; seen_wr = 1'b0; both = 1'b0;
    while (bus.resp_valid !== 1'b1 && cyc < 20) begin
      seen_rd |= MemRead; seen_wr |= MemWrite; both |= (MemRead & MemWrite);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_resp_seen"}, 64'(bus.resp_valid), 64'd1);
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_rdata"}, bus.resp_rdata, e.rdata);
    chk({tag, "_fault"}, 64'(bus.resp_fault), 64'(e.fault));
    chk({tag, "_memread"}, 64'(seen_rd), 64'(exp_mr));
    chk({tag, "_memwrite"}, 64'(seen_wr), 64'(exp_mw));
    chk({tag, "_no_rd_wr_overlap"}, 64'(both), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse_one_cycle"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    int   acc, pulses;
    logic prev;
    exp_t e;

    for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
    mem[2] = 64'h8877665544332211;
    mem[5] = 64'hDEAD_BEEF_0BAD_F00D;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 64'd0; bus.req_wdata = 64'd0;
    #1;
    // reset state, before any clock edge
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_memread", 64'(MemRead), 64'd0);
    chk("rst_memwrite", 64'(MemWrite), 64'd0);
    chk("rst_address", address, 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // loads, sign/zero extension
    run_req("lb_17",  1'b0, 3'b000, 64'h17, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2, 1'b1, 1'b0);
    run_req("lbu_17", 1'b0, 3'b100, 64'h17, 64'd0, 64'h0000_0000_0000_0088, 1'b0, 2, 1'b1, 1'b0);
    run_req("lh_16",  1'b0, 3'b001, 64'h16, 64'd0, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 2, 1'b1, 1'b0);
    run_req("lwu_14", 1'b0, 3'b110, 64'h14, 64'd0, 64'h0000_0000_8877_6655, 1'b0, 2, 1'b1, 1'b0);
    run_req("lw_10",  1'b0, 3'b010, 64'h10, 64'd0, 64'h0000_0000_4433_2211, 1'b0, 2, 1'b1, 1'b0);
    run_req("ld_10",  1'b0, 3'b011, 64'h10, 64'd0, 64'h8877_6655_4433_2211, 1'b0, 2, 1'b1, 1'b0);

    // sub-dword store: read-modify-write
    run_req("sh_12", 1'b1, 3'b001, 64'h12, 64'hFFFF_FFFF_FFFF_ABCD, 64'd0, 1'b0, 3, 1'b1, 1'b1);
    chk("sh_12_mem", mem[2], 64'h8877_6655_ABCD_2211);

    // misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    run_req("lw_13", 1'b0, 3'b010, 64'h13, 64'd0, 64'd0, 1'b1, 1, 1'b0, 1'b0);
`else
    run_req("lw_13", 1'b0, 3'b010, 64'h13, 64'd0, 64'hFFFF_FFFF_ABCD_2211, 1'b0, 2, 1'b1, 1'b0);
`endif

    // out-of-range and illegal encodings
    run_req("sd_oor", 1'b1, 3'b011, 64'd8192, 64'h1111, 64'd0, 1'b1, 1, 1'b0, 1'b0);
    run_req("ld_f7",  1'b0, 3'b111, 64'h10, 64'd0, 64'd0, 1'b1, 1, 1'b0, 1'b0);
    run_req("sbu",    1'b1, 3'b100, 64'h10, 64'h77, 64'd0, 1'b1, 1, 1'b0, 1'b0);
    chk("fault_mem_untouched", mem[2], 64'h8877_6655_ABCD_2211);

    // full dword store
    run_req("sd_18", 1'b1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 2, 1'b0, 1'b1);
    chk("sd_18_mem", mem[3], 64'h0123_4567_89AB_CDEF);

    // reset asserted while a byte store is in WR
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 64'h18; bus.req_wdata = 64'h5A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("abort_in_rd", 64'(MemRead), 64'd1);
    @(posedge clk); #1;
    chk("abort_in_wr", 64'(MemWrite), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_memwrite_now", 64'(MemWrite), 64'd0);
    chk("abort_ready_now", 64'(bus.req_ready), 64'd1);
    chk("abort_address_now", address, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_resp_in_rst", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1 || MemWrite === 1'b1) pulses++;
    end
    chk("abort_no_resp_or_write", 64'(pulses), 64'd0);
    chk("abort_mem_unchanged", mem[3], 64'h0123_4567_89AB_CDEF);

    // three back-to-back dword loads with req_valid held high
    for (int k = 0; k < 3; k++) begin
      e.rdata = 64'hDEAD_BEEF_0BAD_F00D; e.fault = 1'b0; e.lat = 2;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b011;
    bus.req_addr = 64'h28; bus.req_wdata = 64'd0;
    acc = 0; pulses = 0; prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (prev) chk("b2b_ready_after_resp", 64'(bus.req_ready), 64'd1);
      prev = bus.resp_valid;
      if (bus.resp_valid === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_rdata", bus.resp_rdata, e.rdata);
          chk("b2b_fault", 64'(bus.resp_fault), 64'(e.fault));
        end
      end
      if (bus.req_ready === 1'b1 && bus.req_valid === 1'b1) acc++;
      @(posedge clk); #1;
      if (acc == 3) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_accepts", 64'(acc), 64'd3);
    chk("b2b_pulses", 64'(pulses), 64'd3);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 1024, number of 64-bit data memory entries.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  core request present.
REQ-005 SHALL have port: req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port: req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RISC-V size/sign code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-008 SHALL have port: req_addr  input  64  byte address.
REQ-009 SHALL have port: req_wdata  input  64  store data, right-aligned.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: resp_rdata  output  64  load result, extended to 64 bits; 0 for stores and faults.
REQ-012 SHALL have port: resp_fault  output  1  misaligned, out-of-range or illegal funct3; valid with resp_valid.
REQ-013 SHALL have port: address  output  64  data memory entry index = {3'b0, addr[63:3]}.
REQ-014 SHALL have port: WriteData  output  64  full dword written to memory.
REQ-015 SHALL have port: MemRead  output  1  memory read enable.
REQ-016 SHALL have port: MemWrite  output  1  memory write enable, committed at rising edge.
REQ-017 SHALL have port: ReadData  input  64  combinational memory read data; 0 when MemRead=0.

Function
REQ-018 SHALL implement states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge with req_valid=1 in IDLE, registering store, funct3, addr and wdata; inputs are ignored in all other states.
REQ-020 SHALL decode at accept: fault if funct3=111, store with funct3 in {100,101,110}, dword index >= MEM_WORDS, or misaligned (h: addr[0]!=0; w: addr[1:0]!=0; d: addr[2:0]!=0).
REQ-021 SHALL transition on a fault IDLE->RESP with no memory access.
REQ-022 SHALL transition on a load IDLE->RD->RESP: MemRead=1 in RD; ReadData captured at the end of RD.
REQ-023 SHALL transition on a d store IDLE->WR->RESP: WriteData=wdata and MemWrite=1 in WR.
REQ-024 SHALL transition on a b/h/w store IDLE->RD->WR->RESP: read-modify-write, in which only the addressed lanes (offset addr[2:0]) are replaced by the low bytes of wdata and all other bytes are preserved.
REQ-025 SHALL extract the load lane at offset addr[2:0]: sign-extend for b/h/w; zero-extend for bu/hu/wu; pass d unmodified.
REQ-026 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; back-to-back requests are accepted in the following IDLE cycle.
REQ-027 SHALL hold MemRead=0 and MemWrite=0 in IDLE and RESP, and never assert both in the same cycle.
REQ-028 SHALL drive address from the registered request in RD and WR, and 0 otherwise.
REQ-029 SHALL have latency, accept edge to resp_valid cycle: fault 1, d store 2, load 2, sub-dword store 3.

Reset
REQ-030 SHALL, while rst=0, force state to IDLE with req_ready=1 and all other outputs 0, independent of clk.
REQ-031 SHALL abandon any in-flight operation when rst is asserted: no MemWrite after assertion and no resp_valid for the aborted request.

Configuration
REQ-032 SHALL use LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses fault per REQ-020; when undefined, misalignment is not a fault and the offset is truncated to natural alignment (h clears addr[0]; w clears addr[1:0]; d clears addr[2:0]).

Verification
REQ-033 SHALL cover: preload mem[2]=0x8877665544332211, lb addr 0x17 -> resp_rdata 0x0000000000000088? no, sign-extended 0xFFFFFFFFFFFFFF88, 2 cycles.
REQ-034 SHALL cover: sh wdata 0xABCD at 0x12 over mem[2]=0x8877665544332211 -> 3 cycles, mem[2]=0x88776655ABCD2211.
REQ-035 SHALL cover: lw addr 0x13 with LSU_MISALIGN_TRAP_EN defined -> resp_fault=1 after 1 cycle, MemRead never asserted.
REQ-036 SHALL cover: sd addr 8*1024 with MEM_WORDS=1024 -> resp_fault=1, MemWrite never asserted.
REQ-037 SHALL cover: rst driven low during WR of a sb -> MemWrite=0 immediately, memory unchanged, no resp_valid.
REQ-038 SHALL cover: req_valid held high for three back-to-back ld requests -> exactly three resp_valid pulses, each followed by one req_ready=1 cycle.
